// File: rtl/shift_add_mult4_pkg.sv
// Shared types and sizes for the sequential shift-and-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;
   localparam int ITERS  = 4;

endpackage : mult_pkg

// File: rtl/shift_add_mult4_rca.sv
// 4-bit ripple-carry adder: sum_o/c_o = a_i + b_i + cin_i.
module rca4
   import mult_pkg::*;
(
   input  logic [OP_W-1:0] a_i,
   input  logic [OP_W-1:0] b_i,
   input  logic            cin_i,
   output logic [OP_W-1:0] sum_o,
   output logic            c_o
);

   // Carry ripples bit by bit from cin_i up to c_o.
   always_comb begin : ripple
      logic [OP_W:0] carry;
      carry    = '0;
      sum_o    = '0;
      carry[0] = cin_i;
      for (int i = 0; i < OP_W; i++) begin
         sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
      c_o = carry[OP_W];
   end

endmodule : rca4

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift step per clock
// through a single RCA, valid/ready on both the operand and product sides.
module shift_add_mult4
   import mult_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_a,
   input  logic [OP_W-1:0]   in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] out_prod,
   output logic              busy
);

   // The datapath adder is fixed at 4 bits, so no other width can work.
   generate
      if (WIDTH != OP_W) begin : g_bad_width
         $error("shift_add_mult4: WIDTH must be 4");
      end
   endgenerate

   mult_state_t     state_q, state_d;
   logic [OP_W-1:0] mcand_q, mcand_d;
   logic [OP_W-1:0] hi_q,    hi_d;
   logic [OP_W-1:0] lo_q,    lo_d;
   logic [1:0]      cnt_q,   cnt_d;

   logic [OP_W-1:0] rca_sum;
   logic            rca_c;
   logic [OP_W:0]   add_res;

   // Adder always computes hi + mcand; lo[0] decides below whether it is used.
   rca4 u_rca (
      .a_i   (hi_q),
      .b_i   (mcand_q),
      .cin_i (1'b0),
      .sum_o (rca_sum),
      .c_o   (rca_c)
   );

   // Next-state logic: accept in IDLE, iterate in RUN, hold product in DONE.
   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      add_res = lo_q[0] ? {rca_c, rca_sum} : {1'b0, hi_q};
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               mcand_d = in_a;
               lo_d    = in_b;
               hi_d    = '0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // {c, sum, lo} shifted right by one; the dropped bit is the
            // multiplier bit just consumed.
            hi_d  = add_res[OP_W:1];
            lo_d  = {add_res[0], lo_q[OP_W-1:1]};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'(ITERS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mcand_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
      end
   end

   // All outputs decode registered state only; no input-to-output paths.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_prod  = {hi_q, lo_q};

endmodule : shift_add_mult4

// File: tb/tb_shift_add_mult4.sv
// Directed and exhaustive checks for shift_add_mult4 with a product scoreboard.
module tb_shift_add_mult4;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_prod;
   logic       busy;

   int         n_cmp;
   int         n_mis;
   int         cyc;
   logic [7:0] sb[$];

   shift_add_mult4 #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer a pair, wait for the accept edge, push the expected product.
   task automatic send(input int a, input int b, input bit keep, output int acc_cyc);
      int n;
      n = 0;
      acc_cyc = -1;
      in_a = 4'(a);
      in_b = 4'(b);
      in_valid = 1'b1;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         sb.push_back(8'(a * b));
         acc_cyc = cyc;
         tick();
      end
      if (!keep) in_valid = 1'b0;
   endtask

   // Wait for a product, optionally stall it, then pop and compare on handshake.
   // lat = edges from the accept edge to the first edge that samples out_valid high.
   task automatic recv(input int stall, input bit rnd_rdy, output int lat);
      int         n;
      logic [7:0] exp;
      n = 0;
      while (!out_valid && n < 20) begin
         out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         n++;
      end
      out_ready = 1'b0;
      lat = n + 1;
      if (!out_valid) begin
         chk("out_valid_timeout", 32'd0, 32'd1);
         return;
      end
      if (sb.size() == 0) begin
         chk("sb_underflow", 32'd0, 32'd1);
         exp = 8'h00;
      end else begin
         exp = sb.pop_front();
      end
      for (int i = 0; i < stall; i++) begin
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_prod", 32'(out_prod), 32'(exp));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      chk("prod", 32'(out_prod), 32'(exp));
      chk("busy_done", 32'(busy), 32'd1);
      tick();
      out_ready = 1'b0;
      chk("valid_fall", 32'(out_valid), 32'd0);
      chk("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   initial begin
      int lat;
      int acc0;
      int acc1;
      int nv;
      n_cmp = 0;
      n_mis = 0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      out_ready = 1'b0;
      tick();
      tick();

      // Reset values
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_prod", 32'(out_prod), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // 11 * 13 = 0x8F, latency 5
      send(11, 13, 1'b0, acc0);
      chk("busy_run", 32'(busy), 32'd1);
      chk("in_ready_run", 32'(in_ready), 32'd0);
      recv(0, 1'b0, lat);
      chk("lat_11x13", 32'(lat), 32'd5);

      // Edge operands
      send(15, 15, 1'b0, acc0);
      recv(0, 1'b0, lat);
      send(0, 9, 1'b0, acc0);
      recv(0, 1'b0, lat);
      chk("lat_0x9", 32'(lat), 32'd5);
      send(7, 0, 1'b0, acc0);
      recv(0, 1'b0, lat);
      chk("lat_7x0", 32'(lat), 32'd5);

      // Backpressure with a competing in_valid held during the stall
      send(6, 9, 1'b0, acc0);
      in_a = 4'd1;
      in_b = 4'd1;
      in_valid = 1'b1;
      recv(10, 1'b0, lat);
      in_valid = 1'b0;
      tick();
      chk("no_stray_accept", 32'(busy), 32'd0);

      // Back-to-back with in_valid held high
      send(3, 5, 1'b1, acc0);
      in_a = 4'd12;
      in_b = 4'd4;
      recv(0, 1'b0, lat);
      send(12, 4, 1'b0, acc1);
      chk("b2b_interval", 32'(acc1 - acc0), 32'd6);
      recv(0, 1'b0, lat);

      // Reset two cycles after accepting 9*9
      send(9, 9, 1'b0, acc0);
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      void'(sb.pop_back());
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_prod", 32'(out_prod), 32'd0);
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) nv++;
         tick();
      end
      chk("midrst_no_valid", 32'(nv), 32'd0);
      send(2, 3, 1'b0, acc0);
      recv(0, 1'b0, lat);
      chk("lat_2x3", 32'(lat), 32'd5);

      // Exhaustive with random stalls and random early out_ready
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            send(a, b, 1'b0, acc0);
            recv(int'($urandom_range(0, 2)), 1'b1, lat);
         end
      end
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_shift_add_mult4
